proj_fm_min_scanner: RTL and testbench

- Downstream stage of the FM index counter.
- Consumes one hash sample per counter index over a full buffer sweep (index 0..FM_BUFFER_SIZE-1).
- Tracks the running minimum hash and its index, and emits one MinHash result per sweep through a valid/ready output register.
- Double-buffered: the accumulator restarts immediately on sweep end while the previous result waits for the consumer.

---
 rtl/proj_pkg.sv | 21 ++
 rtl/proj_fm_min_out_reg.sv | 52 +++++
 rtl/proj_fm_min_scanner.sv | 78 +++++++
 tb/tb_proj_fm_min_scanner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared types for the FM MinHash path: index/hash widths, result struct, scanner states.
package proj_pkg;

  localparam int FM_BUFFER_SIZE = 4;
  localparam int MINHASH_W      = 32;

  typedef logic [FM_BUFFER_SIZE-1:0] fm_idx_t;
  typedef logic [MINHASH_W-1:0]      minhash_t;

  typedef struct packed {
    minhash_t hash;
    fm_idx_t  idx;
  } min_result_t;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_RUN  = 2'd1,
    SCAN_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/proj_fm_min_out_reg.sv
// Valid/ready holding register for one MinHash result; a load that finds the
// register full and not draining is dropped and flagged in a sticky overflow bit.
module proj_fm_min_out_reg #(
  parameter int IDX_W  = 4,
  parameter int HASH_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [HASH_W-1:0] i_hash,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [HASH_W-1:0] o_hash,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_overflow
);

  logic              r_valid;
  logic [HASH_W-1:0] r_hash;
  logic [IDX_W-1:0]  r_idx;
  logic              r_overflow;
  logic              w_accept;

  assign w_accept = r_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_hash     <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else if (i_load) begin
      // A draining register can take the new result in the same cycle.
      if (!r_valid || w_accept) begin
        r_valid <= 1'b1;
        r_hash  <= i_hash;
        r_idx   <= i_idx;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_hash     = r_hash;
  assign o_idx      = r_idx;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/proj_fm_min_scanner.sv
// Running-minimum scanner over one FM index sweep, one result per sweep.
// Build option PROJ_FM_MIN_SCAN_TIE_LAST_EN: equal hashes move the minimum to the later index.
module proj_fm_min_scanner
  import proj_pkg::*;
#(
  parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
  parameter int HASH_W         = proj_pkg::MINHASH_W
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_sample_valid,
  input  logic [FM_BUFFER_SIZE-1:0] in_index,
  input  logic [HASH_W-1:0]         in_hash,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [HASH_W-1:0]         out_min_hash,
  output logic [FM_BUFFER_SIZE-1:0] out_min_index,
  output logic                      out_overflow
);

  scan_state_e               r_state;
  logic [HASH_W-1:0]         r_acc_min;
  logic [FM_BUFFER_SIZE-1:0] r_acc_idx;

  logic                      w_first;
  logic                      w_better;
  logic                      w_push;
  logic [HASH_W-1:0]         w_cand_hash;
  logic [FM_BUFFER_SIZE-1:0] w_cand_idx;

  // Outside SCAN_RUN the incoming sample always opens a new sweep.
  assign w_first = (r_state != SCAN_RUN);

`ifdef PROJ_FM_MIN_SCAN_TIE_LAST_EN
  assign w_better = (in_hash <= r_acc_min);
`else
  assign w_better = (in_hash < r_acc_min);
`endif

  assign w_cand_hash = (w_first || w_better) ? in_hash  : r_acc_min;
  assign w_cand_idx  = (w_first || w_better) ? in_index : r_acc_idx;

  // The candidate including the last sample's compare goes straight to the
  // output register so the result appears the cycle after in_last.
  assign w_push = in_sample_valid && in_last;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state   <= SCAN_IDLE;
      r_acc_min <= '0;
      r_acc_idx <= '0;
    end else if (in_sample_valid) begin
      r_acc_min <= w_cand_hash;
      r_acc_idx <= w_cand_idx;
      r_state   <= in_last ? SCAN_DONE : SCAN_RUN;
    end else if (r_state == SCAN_DONE) begin
      r_state <= SCAN_IDLE;
    end
  end

  proj_fm_min_out_reg #(
    .IDX_W  (FM_BUFFER_SIZE),
    .HASH_W (HASH_W)
  ) u_out_reg (
    .i_clk      (in_clk),
    .i_rst_n    (in_rst_n),
    .i_load     (w_push),
    .i_hash     (w_cand_hash),
    .i_idx      (w_cand_idx),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_hash     (out_min_hash),
    .o_idx      (out_min_index),
    .o_overflow (out_overflow)
  );

endmodule

// File: tb/tb_proj_fm_min_scanner.sv
// Bench for proj_fm_min_scanner: directed sweeps plus random sweeps against a sweep-level model.
module tb_proj_fm_min_scanner;

  localparam int N  = 4;
  localparam int HW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sv;
  logic [N-1:0]  idx;
  logic [HW-1:0] hash;
  logic          last;
  logic          ready;
  logic          o_valid;
  logic [HW-1:0] o_hash;
  logic [N-1:0]  o_idx;
  logic          o_ovf;

  proj_fm_min_scanner #(.FM_BUFFER_SIZE(N), .HASH_W(HW)) dut (
    .in_clk          (clk),
    .in_rst_n        (rst_n),
    .in_sample_valid (sv),
    .in_index        (idx),
    .in_hash         (hash),
    .in_last         (last),
    .out_valid       (o_valid),
    .out_ready       (ready),
    .out_min_hash    (o_hash),
    .out_min_index   (o_idx),
    .out_overflow    (o_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Sweep-level reference: samples collected per sweep, result register state.
  logic [HW-1:0] q_h[$];
  logic [N-1:0]  q_i[$];
  bit            m_valid;
  bit            m_ovf;
  logic [HW-1:0] m_hash;
  logic [N-1:0]  m_idx;

`ifdef PROJ_FM_MIN_SCAN_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_h.delete();
    q_i.delete();
    m_valid = 0;
    m_ovf   = 0;
    m_hash  = '0;
    m_idx   = '0;
  endtask

  // Minimum of the collected sweep; tie rule picks first or last equal value.
  task automatic sweep_min(output logic [HW-1:0] bh, output logic [N-1:0] bi);
    bh = q_h[0];
    bi = q_i[0];
    foreach (q_h[k]) begin
      if (q_h[k] < bh || (TIE_LAST && q_h[k] == bh)) begin
        bh = q_h[k];
        bi = q_i[k];
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
    chk({tag, ".ovf"},   64'(o_ovf),   64'(m_ovf));
    if (m_valid) begin
      chk({tag, ".hash"}, 64'(o_hash), 64'(m_hash));
      chk({tag, ".idx"},  64'(o_idx),  64'(m_idx));
    end
  endtask

  // Advance the model with the currently driven inputs, clock once, compare.
  task automatic step(input string tag);
    logic [HW-1:0] nh;
    logic [N-1:0]  ni;
    bit push, acc;
    push = 0;
    nh = '0;
    ni = '0;
    if (sv) begin
      q_h.push_back(hash);
      q_i.push_back(idx);
      if (last) begin
        sweep_min(nh, ni);
        push = 1;
        q_h.delete();
        q_i.delete();
      end
    end
    acc = m_valid && ready;
    if (push) begin
      if (!m_valid || acc) begin
        m_valid = 1;
        m_hash  = nh;
        m_idx   = ni;
      end else begin
        m_ovf = 1;
      end
    end else if (acc) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic sample(input logic [N-1:0] i, input logic [HW-1:0] h, input bit l, input string tag);
    sv = 1; idx = i; hash = h; last = l;
    step(tag);
  endtask

  // Idle cycle with junk on index/last to exercise input gating.
  task automatic idle(input string tag);
    sv = 0; idx = N'($urandom); hash = $urandom; last = 1'($urandom);
    step(tag);
  endtask

  task automatic sweep4(input logic [HW-1:0] h0, h1, h2, h3, input string tag);
    sample(0, h0, 0, tag);
    sample(1, h1, 0, tag);
    sample(2, h2, 0, tag);
    sample(3, h3, 1, tag);
  endtask

  initial begin
    rst_n = 0; sv = 0; idx = '0; hash = '0; last = 0; ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 64'(o_valid), 0);
    chk("rst.hash",  64'(o_hash),  0);
    chk("rst.idx",   64'(o_idx),   0);
    chk("rst.ovf",   64'(o_ovf),   0);
    rst_n = 1;
    idle("rst.idle");

    // Basic sweep: result visible the cycle after idx 3.
    sweep4(9, 3, 7, 5, "basic");
    chk("basic.hash", 64'(o_hash), 3);
    chk("basic.idx",  64'(o_idx),  1);
    idle("basic.drain");
    chk("basic.drop", 64'(o_valid), 0);

    // Tie handling.
    sweep4(4, 2, 8, 2, "tie");
    chk("tie.idx", 64'(o_idx), TIE_LAST ? 3 : 1);
    idle("tie.drain");

    // Back-to-back sweeps, no bubble.
    sweep4(9, 3, 7, 5, "b2b1");
    chk("b2b1.hash", 64'(o_hash), 3);
    chk("b2b1.idx",  64'(o_idx),  1);
    sweep4(1, 6, 6, 6, "b2b2");
    chk("b2b2.hash", 64'(o_hash), 1);
    chk("b2b2.idx",  64'(o_idx),  0);
    chk("b2b2.ovf",  64'(o_ovf),  0);
    idle("b2b.drain");

    // Pending result drained in the same cycle the next result lands.
    ready = 0;
    sweep4(9, 3, 7, 5, "simA");
    sample(0, 1, 0, "simB");
    sample(1, 6, 0, "simB");
    sample(2, 6, 0, "simB");
    ready = 1;
    sample(3, 6, 1, "simB");
    chk("sim.valid", 64'(o_valid), 1);
    chk("sim.hash",  64'(o_hash),  1);
    chk("sim.ovf",   64'(o_ovf),   0);
    idle("sim.drain");

    // Overflow: second result dropped, first held.
    ready = 0;
    sweep4(9, 3, 7, 5, "ovfA");
    sweep4(1, 6, 6, 6, "ovfB");
    idle("ovf.hold");
    chk("ovf.hash", 64'(o_hash), 3);
    chk("ovf.idx",  64'(o_idx),  1);
    chk("ovf.flag", 64'(o_ovf),  1);
    ready = 1;
    idle("ovf.accept");
    chk("ovf.valid", 64'(o_valid), 0);

    // Asynchronous reset mid-sweep.
    sample(0, 0, 0, "arst");
    sample(1, 5, 0, "arst");
    sv = 0;
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("arst.valid", 64'(o_valid), 0);
    chk("arst.hash",  64'(o_hash),  0);
    chk("arst.idx",   64'(o_idx),   0);
    chk("arst.ovf",   64'(o_ovf),   0);
    @(posedge clk);
    #2 rst_n = 1;
    sweep4(7, 8, 9, 6, "post");
    chk("post.hash", 64'(o_hash), 6);
    chk("post.idx",  64'(o_idx),  3);

    // Random sweeps: varied lengths, gaps, ready and hash ranges.
    for (int s = 0; s < 400; s++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        logic [HW-1:0] h;
        h = ($urandom_range(0, 3) != 0) ? HW'($urandom_range(0, 7)) : HW'($urandom);
        ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) idle("rnd.gap");
        ready = ($urandom_range(0, 3) != 0);
        sample(N'($urandom), h, (k == len - 1), "rnd");
      end
    end
    ready = 1;
    idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
